// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX stream arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

  // Width needed to hold a source id for n sources; never less than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin pick: first asserted request at or after ptr, wrapping mod NUM_SRC.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = id_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  logic [2*NUM_SRC-1:0] dbl;
  logic [NUM_SRC-1:0]   rot;

  // Rotate the request vector so that position 0 corresponds to ptr.
  always_comb begin
    dbl = {req, req};
    rot = NUM_SRC'(dbl >> ptr);
  end

  // Priority-encode the rotated vector and map the offset back to a source id.
  always_comb begin
    logic [ID_W:0] sum;
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (ID_W+1)'(i);
        if (sum >= (ID_W+1)'(NUM_SRC)) sum = sum - (ID_W+1)'(NUM_SRC);
        idx   = sum[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the UART bridge TX stream,
// with an optional one-byte source-id header ahead of each packet.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned              NUM_SRC    = 4,
  parameter int unsigned              DATA_WIDTH = 8,
  parameter bit                       HEADER_EN  = 1'b1,
  parameter logic [DATA_WIDTH-1:0]    HDR_BASE   = DATA_WIDTH'(HDR_BASE_DEFAULT),
  parameter int unsigned              MAX_LEN    = 64,
  localparam int unsigned             ID_W       = id_width(NUM_SRC),
  localparam int unsigned             CNT_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  input  logic [NUM_SRC-1:0]            s_tlast,
  output logic [NUM_SRC-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          pkt_done,
  output logic                          len_err
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              at_max;

  rr_picker #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_picker (
    .req   (s_tvalid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign at_max   = (cnt_q == CNT_W'(MAX_LEN - 1));
  assign grant_id = grant_q;

  // State, pointer, grant and beat-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: arbitrate in IDLE, advance past the header, count payload beats.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (enable && pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = HEADER_EN ? HEADER : PAYLOAD;
        end
      end
      HEADER: begin
        if (m_tready) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (m_tvalid && m_tready) begin
          cnt_d = cnt_q + 1'b1;
          if (m_tlast) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == ID_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: header beat, or combinational pass-through of the granted source.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    s_tready = '0;
    busy     = 1'b0;
    pkt_done = 1'b0;
    len_err  = 1'b0;
    case (state_q)
      HEADER: begin
        busy     = 1'b1;
        m_tvalid = 1'b1;
        m_tdata  = {HDR_BASE[DATA_WIDTH-1:ID_W], grant_q};
      end
      PAYLOAD: begin
        busy              = 1'b1;
        m_tvalid          = s_tvalid[grant_q];
        m_tdata           = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        m_tlast           = s_tlast[grant_q] | at_max;
        s_tready[grant_q] = m_tready;
        pkt_done          = s_tvalid[grant_q] & m_tready & m_tlast;
        // Truncation is a forced end while the source itself has not ended.
        len_err           = s_tvalid[grant_q] & m_tready & at_max & ~s_tlast[grant_q];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (NUM_SRC=4, MAX_LEN=4, header on).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tlast;
  logic [3:0]  s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic        busy;
  logic [1:0]  grant_id;
  logic        pkt_done;
  logic        len_err;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] tv;
    logic [3:0] tl;
    logic [31:0] td;
    logic       mr;
    logic       mv;
    logic [7:0] md;
    logic       ml;
    logic [3:0] sr;
    logic       bsy;
    logic [1:0] gid;
    logic       done;
    logic       lerr;
  } vec_t;

  vec_t tbl[$];

  uart_tx_arbiter #(
    .NUM_SRC    (4),
    .DATA_WIDTH (8),
    .HEADER_EN  (1'b1),
    .HDR_BASE   (8'hA0),
    .MAX_LEN    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .busy     (busy),
    .grant_id (grant_id),
    .pkt_done (pkt_done),
    .len_err  (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic en, input logic [3:0] tv,
                              input logic [3:0] tl, input logic [31:0] td, input logic mr,
                              input logic mv, input logic [7:0] md, input logic ml,
                              input logic [3:0] sr, input logic bsy, input logic [1:0] gid,
                              input logic done, input logic lerr);
    vec_t v;
    v.rst = r;  v.en = en; v.tv = tv; v.tl = tl; v.td = td; v.mr = mr;
    v.mv = mv;  v.md = md; v.ml = ml; v.sr = sr; v.bsy = bsy; v.gid = gid;
    v.done = done; v.lerr = lerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic check_row(input string tag, input vec_t v);
    chk({tag, " m_tvalid"}, 32'(m_tvalid), 32'(v.mv));
    if (v.mv) begin
      chk({tag, " m_tdata"}, 32'(m_tdata), 32'(v.md));
      chk({tag, " m_tlast"}, 32'(m_tlast), 32'(v.ml));
    end
    chk({tag, " s_tready"}, 32'(s_tready), 32'(v.sr));
    chk({tag, " busy"},     32'(busy),     32'(v.bsy));
    chk({tag, " grant_id"}, 32'(grant_id), 32'(v.gid));
    chk({tag, " pkt_done"}, 32'(pkt_done), 32'(v.done));
    chk({tag, " len_err"},  32'(len_err),  32'(v.lerr));
  endtask

  // One cycle: drive just after the rising edge, check mid-cycle.
  task automatic apply(input string tag, input vec_t v);
    @(posedge clk);
    #1;
    rst      = v.rst;
    enable   = v.en;
    s_tvalid = v.tv;
    s_tlast  = v.tl;
    s_tdata  = v.td;
    m_tready = v.mr;
    #2;
    check_row(tag, v);
  endtask

  vec_t rst_row;
  vec_t idle0;

  initial begin
    rst = 1'b1; enable = 1'b0; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
    rst_row = mk(1, 0, 4'b0000, 4'b0000, 32'h0, 1,  0, 8'h00, 0, 4'b0000, 0, 2'd0, 0, 0);

    // Single source 2: header A2 then 11,22,33 with tlast on 33.
    tbl.push_back(rst_row);
    tbl.push_back(mk(0,1,4'b0100,4'b0000,32'h0011_0000,1, 0,8'h00,0,4'b0000,0,2'd0,0,0));
    tbl.push_back(mk(0,1,4'b0100,4'b0000,32'h0011_0000,1, 1,8'hA2,0,4'b0000,1,2'd2,0,0));
    tbl.push_back(mk(0,1,4'b0100,4'b0000,32'h0011_0000,1, 1,8'h11,0,4'b0100,1,2'd2,0,0));
    tbl.push_back(mk(0,1,4'b0100,4'b0000,32'h0022_0000,1, 1,8'h22,0,4'b0100,1,2'd2,0,0));
    tbl.push_back(mk(0,1,4'b0100,4'b0100,32'h0033_0000,1, 1,8'h33,1,4'b0100,1,2'd2,1,0));
    tbl.push_back(mk(0,1,4'b0000,4'b0000,32'h0000_0000,1, 0,8'h00,0,4'b0000,0,2'd2,0,0));
    // Sources 0 and 1 together from reset: 0 first (01,02), idle gap, then 1 (B1).
    tbl.push_back(rst_row);
    tbl.push_back(mk(0,1,4'b0011,4'b0010,32'h0000_B101,1, 0,8'h00,0,4'b0000,0,2'd0,0,0));
    tbl.push_back(mk(0,1,4'b0011,4'b0010,32'h0000_B101,1, 1,8'hA0,0,4'b0000,1,2'd0,0,0));
    tbl.push_back(mk(0,1,4'b0011,4'b0010,32'h0000_B101,1, 1,8'h01,0,4'b0001,1,2'd0,0,0));
    tbl.push_back(mk(0,1,4'b0011,4'b0011,32'h0000_B102,1, 1,8'h02,1,4'b0001,1,2'd0,1,0));
    tbl.push_back(mk(0,1,4'b0010,4'b0010,32'h0000_B100,1, 0,8'h00,0,4'b0000,0,2'd0,0,0));
    tbl.push_back(mk(0,1,4'b0010,4'b0010,32'h0000_B100,1, 1,8'hA1,0,4'b0000,1,2'd1,0,0));
    tbl.push_back(mk(0,1,4'b0010,4'b0010,32'h0000_B100,1, 1,8'hB1,1,4'b0010,1,2'd1,1,0));
    tbl.push_back(mk(0,1,4'b0000,4'b0000,32'h0000_0000,1, 0,8'h00,0,4'b0000,0,2'd1,0,0));
    // Source 3 with m_tready toggling: output held while stalled.
    tbl.push_back(rst_row);
    tbl.push_back(mk(0,1,4'b1000,4'b0000,32'hC100_0000,0, 0,8'h00,0,4'b0000,0,2'd0,0,0));
    tbl.push_back(mk(0,1,4'b1000,4'b0000,32'hC100_0000,0, 1,8'hA3,0,4'b0000,1,2'd3,0,0));
    tbl.push_back(mk(0,1,4'b1000,4'b0000,32'hC100_0000,1, 1,8'hA3,0,4'b0000,1,2'd3,0,0));
    tbl.push_back(mk(0,1,4'b1000,4'b0000,32'hC100_0000,0, 1,8'hC1,0,4'b0000,1,2'd3,0,0));
    tbl.push_back(mk(0,1,4'b1000,4'b0000,32'hC100_0000,1, 1,8'hC1,0,4'b1000,1,2'd3,0,0));
    tbl.push_back(mk(0,1,4'b1000,4'b1000,32'hC200_0000,0, 1,8'hC2,1,4'b0000,1,2'd3,0,0));
    tbl.push_back(mk(0,1,4'b1000,4'b1000,32'hC200_0000,1, 1,8'hC2,1,4'b1000,1,2'd3,1,0));
    tbl.push_back(mk(0,1,4'b0000,4'b0000,32'h0000_0000,1, 0,8'h00,0,4'b0000,0,2'd3,0,0));

    foreach (tbl[i]) apply($sformatf("v%0d", i), tbl[i]);

    // Truncation at MAX_LEN=4: source 1 sends D1..D6, tlast on D6.
    apply("tr_rst", rst_row);
    apply("tr_idle", mk(0,1,4'b0010,4'b0000,32'h0000_D100,1, 0,8'h00,0,4'b0000,0,2'd0,0,0));
    apply("tr_hdr1", mk(0,1,4'b0010,4'b0000,32'h0000_D100,1, 1,8'hA1,0,4'b0000,1,2'd1,0,0));
    for (int k = 1; k <= 4; k++) begin
      logic [7:0] d;
      logic       last;
      d    = 8'hD0 + 8'(k);
      last = (k == 4);
      apply($sformatf("tr_b%0d", k),
            mk(0,1,4'b0010,4'b0000,{16'h0,d,8'h0},1, 1,d,last,4'b0010,1,2'd1,last,last));
    end
    apply("tr_gap", mk(0,1,4'b0010,4'b0000,32'h0000_D500,1, 0,8'h00,0,4'b0000,0,2'd1,0,0));
    apply("tr_hdr2", mk(0,1,4'b0010,4'b0000,32'h0000_D500,1, 1,8'hA1,0,4'b0000,1,2'd1,0,0));
    apply("tr_b5", mk(0,1,4'b0010,4'b0000,32'h0000_D500,1, 1,8'hD5,0,4'b0010,1,2'd1,0,0));
    apply("tr_b6", mk(0,1,4'b0010,4'b0010,32'h0000_D600,1, 1,8'hD6,1,4'b0010,1,2'd1,1,0));
    apply("tr_end", mk(0,1,4'b0000,4'b0000,32'h0,1, 0,8'h00,0,4'b0000,0,2'd1,0,0));

    // enable low blocks grants; dropping it mid-packet lets the packet finish.
    apply("en_rst", rst_row);
    idle0 = mk(0,0,4'b1111,4'b1111,32'hE3E2_E1E0,1, 0,8'h00,0,4'b0000,0,2'd0,0,0);
    for (int k = 0; k < 3; k++) apply($sformatf("en_off%0d", k), idle0);
    apply("en_on", mk(0,1,4'b1111,4'b1111,32'hE3E2_E1E0,1, 0,8'h00,0,4'b0000,0,2'd0,0,0));
    apply("en_hdr", mk(0,0,4'b1111,4'b1111,32'hE3E2_E1E0,1, 1,8'hA0,0,4'b0000,1,2'd0,0,0));
    apply("en_pay", mk(0,0,4'b1111,4'b1111,32'hE3E2_E1E0,1, 1,8'hE0,1,4'b0001,1,2'd0,1,0));
    for (int k = 0; k < 3; k++) apply($sformatf("en_hold%0d", k), idle0);

    // Reset mid-payload (rr_ptr is 1 here), then arbitration restarts at source 0.
    apply("rs_idle", mk(0,1,4'b0100,4'b0000,32'h00F1_0000,1, 0,8'h00,0,4'b0000,0,2'd0,0,0));
    apply("rs_hdr", mk(0,1,4'b0100,4'b0000,32'h00F1_0000,1, 1,8'hA2,0,4'b0000,1,2'd2,0,0));
    apply("rs_pay", mk(0,1,4'b0100,4'b0000,32'h00F1_0000,1, 1,8'hF1,0,4'b0100,1,2'd2,0,0));
    #1;
    rst = 1'b1;
    #1;
    check_row("rs_async", mk(1,1,4'b0100,4'b0000,32'h00F1_0000,1,
                             0,8'h00,0,4'b0000,0,2'd0,0,0));
    apply("rs_rel", mk(0,1,4'b0101,4'b0000,32'h00F1_0030,1, 0,8'h00,0,4'b0000,0,2'd0,0,0));
    apply("rs_hdr0", mk(0,1,4'b0101,4'b0000,32'h00F1_0030,1, 1,8'hA0,0,4'b0000,1,2'd0,0,0));
    apply("rs_pay0", mk(0,1,4'b0101,4'b0000,32'h00F1_0030,1, 1,8'h30,0,4'b0001,1,2'd0,0,0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single TX AXI-stream input of the UART bridge between NUM_SRC requesters.
- Arbitrates round-robin and holds the grant for a whole packet, until the requester's tlast.
- Optionally prepends a one-byte source header to each packet so the far end can demultiplex.
- Sits between the internal stream producers and the bridge's TX stream slave port.

Parameters:
- NUM_SRC, 4, number of requesters, 2..8.
- DATA_WIDTH, 8, byte width; must match the UART bridge.
- HEADER_EN, 1, 1 = emit a header beat before each packet payload.
- HDR_BASE, 8'hA0, header byte template; the low ID_W bits are replaced by the source id.
- MAX_LEN, 64, maximum payload beats per grant, 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  when low, no new grant is issued; a packet in flight completes.
- s_tdata  in  NUM_SRC*DATA_WIDTH  requester data; slice i belongs to source i.
- s_tvalid  in  NUM_SRC  per-source valid.
- s_tlast  in  NUM_SRC  per-source end-of-packet.
- s_tready  out  NUM_SRC  per-source ready.
- m_tdata  out  DATA_WIDTH  to bridge TX tdata.
- m_tvalid  out  1  to bridge TX tvalid.
- m_tlast  out  1  end of the forwarded packet.
- m_tready  in  1  from bridge; high when the UART is not busy.
- busy  out  1  high in the HEADER and PAYLOAD states.
- grant_id  out  ID_W  currently or last granted source.
- pkt_done  out  1  one-cycle pulse on the last beat of each packet, normal or truncated.
- len_err  out  1  one-cycle pulse when a packet is truncated at MAX_LEN.

Behaviour:
- ID_W = max(1, clog2(NUM_SRC)). Beat counter width is clog2(MAX_LEN+1).
- Reset values:
  - state IDLE, rr_ptr 0, grant_id 0, beat count 0.
  - m_tvalid, m_tlast, pkt_done, len_err, busy all 0; s_tready all 0.
  - Reset mid-packet aborts immediately. No partial header or payload is resumed.
- States: IDLE, HEADER, PAYLOAD.
- IDLE:
  - m_tvalid=0 and all s_tready=0.
  - If enable and any s_tvalid: pick the first asserted source scanning rr_ptr, rr_ptr+1, ... with wrap mod NUM_SRC.
  - Register the pick into grant_id and clear the beat count.
  - Go to HEADER if HEADER_EN, else PAYLOAD.
  - The grant takes effect the cycle after the decision: one cycle of arbitration latency.
- HEADER:
  - m_tvalid=1, m_tlast=0.
  - m_tdata = {HDR_BASE[DATA_WIDTH-1:ID_W], grant_id}.
  - All s_tready=0.
  - On m_tready go to PAYLOAD.
  - m_tvalid must not drop while m_tready is low.
- PAYLOAD: combinational pass-through of the granted source.
  - m_tdata = s_tdata[grant_id], m_tvalid = s_tvalid[grant_id].
  - m_tlast = s_tlast[grant_id] OR (beat count == MAX_LEN-1).
  - s_tready[grant_id] = m_tready; all other s_tready=0.
  - Each accepted beat (m_tvalid & m_tready) increments the beat count.
- Packet end: an accepted beat with m_tlast=1.
  - pkt_done pulses in the same cycle, registered-output-free (comb from the accept).
  - State returns to IDLE; rr_ptr = (grant_id+1) mod NUM_SRC.
- Truncation: if the packet end was forced by MAX_LEN while s_tlast=0, len_err pulses with pkt_done.
  - The source's remaining beats are treated as a new packet at its next grant.
- Inter-packet gap: at least one idle cycle between consecutive packets (the IDLE arbitration cycle).
- enable falling mid-packet has no effect until the return to IDLE.
- A source deasserting s_tvalid mid-packet stalls the output; the grant is held. There is no timeout.
- rr_ptr advances only on packet completion. A lone requester is re-granted every packet.

Decomposition:
- Package uart_arb_pkg:
  - state enum (IDLE, HEADER, PAYLOAD).
  - function id_width(n).
  - default HDR_BASE constant.
- Sub-module rr_picker:
  - Combinational.
  - Inputs: req[NUM_SRC], ptr[ID_W].
  - Outputs: found, idx[ID_W]. Rotate-and-priority-encode.

Test Plan:
- Single source 2 sends {11,22,33} with tlast on 33, HEADER_EN=1, m_tready=1 -> m_tdata stream A2,11,22,33; m_tlast on 33; pkt_done once; rr_ptr=3.
- Sources 0 and 1 request simultaneously from reset -> packets in the order 0 then 1; headers A0, A1; one idle cycle between them; each packet complete and uninterleaved.
- m_tready toggled every other cycle during header and payload -> no beat lost or duplicated; m_tvalid and m_tdata stable while stalled; non-granted s_tready stays 0.
- MAX_LEN=4, source 1 sends 6 beats with tlast on beat 6 -> first grant forwards 4 beats with m_tlast on beat 4 plus len_err; the next grant for source 1 forwards beats 5-6.
- enable=0 with all sources valid -> m_tvalid stays 0; enable deasserted mid-packet -> the current packet finishes, then no new grant.
- rst asserted mid-payload -> in the same cycle m_tvalid=0, s_tready=0, busy=0; after release, arbitration restarts from source 0.
